// File: rtl/rf_bypass_sb.sv
// Purpose: parametrised 2-read/1-write integer register file with a
//          same-cycle write-to-read bypass and a per-register busy
//          scoreboard carrying an outstanding-write counter.
// Latency: reads are combinational; writes, busy bits and busy_cnt take
//          effect on the next rising edge. The bypass shows wd in the write cycle.
// Backpressure: none. Writes always complete and never fault. Stalling on
//          busy1/busy2 is the decode stage's decision.
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   we, wa, wd        writeback write port (also clears busy[wa])
//   ra1/ra2 -> rd1/rd2, busy1/busy2   read ports and scoreboard lookups
//   sb_set, sb_sa     issue-time scoreboard set
//   busy_cnt          number of registers currently busy
//   dbg_sel->dbg_data debug read of the array, never bypassed
module rf_bypass_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_sa,
  output logic [AW:0]   busy_cnt,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  localparam int          NREG    = 1 << AW;
  localparam logic [AW:0] CNT_ONE = 1;

  logic [DW-1:0]   r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_cnt;

  logic w_wr_en;
  logic w_set_en;
  logic w_inc;
  logic w_dec;
  logic w_zero1, w_zero2;
  logic w_byp1, w_byp2;
  logic w_set1, w_set2;

  // Register 0 swallows writes and scoreboard sets when hardwired to zero.
  assign w_wr_en  = we && !((ZERO_REG != 0) && (wa == '0));
  assign w_set_en = sb_set && !((ZERO_REG != 0) && (sb_sa == '0));

  // The counter follows the actual busy-bit transitions: a set only counts
  // when it makes a register busy, and a clear only counts when it frees one
  // that is not re-claimed by a set in the same cycle.
  assign w_inc = w_set_en && !r_busy[sb_sa];
  assign w_dec = we && r_busy[wa] && !(w_set_en && (sb_sa == wa));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_en) begin
        r_rf[wa] <= wd;
      end
      // Set is written after clear so that a newer producer issuing to the
      // same register in the writeback cycle keeps it busy.
      if (we) begin
        r_busy[wa] <= 1'b0;
      end
      if (w_set_en) begin
        r_busy[sb_sa] <= 1'b1;
      end
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_zero1 = (ZERO_REG != 0) && (ra1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (ra2 == '0);
  assign w_byp1  = (BYPASS != 0) && we && (wa == ra1);
  assign w_byp2  = (BYPASS != 0) && we && (wa == ra2);
  assign w_set1  = sb_set && (sb_sa == ra1);
  assign w_set2  = sb_set && (sb_sa == ra2);

  assign rd1 = w_zero1 ? '0 : (w_byp1 ? wd : r_rf[ra1]);
  assign rd2 = w_zero2 ? '0 : (w_byp2 ? wd : r_rf[ra2]);

  // A bypassed read already has its data, so it is not reported busy, unless
  // a new producer is claiming the same register this cycle.
  assign busy1 = w_zero1 ? 1'b0 : ((w_byp1 && !w_set1) ? 1'b0 : r_busy[ra1]);
  assign busy2 = w_zero2 ? 1'b0 : ((w_byp2 && !w_set2) ? 1'b0 : r_busy[ra2]);

  assign busy_cnt = r_cnt;
  assign dbg_data = r_rf[dbg_sel];

endmodule

// File: tb/tb_rf_bypass_sb.sv
module tb_rf_bypass_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: default parameters (DW=32, AW=5, BYPASS=1, ZERO_REG=1)
  logic        a_we, a_ss;
  logic [4:0]  a_wa, a_ra1, a_ra2, a_sa, a_dsel;
  logic [31:0] a_wd, a_rd1, a_rd2, a_dbg;
  logic        a_b1, a_b2;
  logic [5:0]  a_cnt;

  rf_bypass_sb u_dut_a (
    .clk(clk), .rst(rst), .we(a_we), .wa(a_wa), .wd(a_wd),
    .ra1(a_ra1), .ra2(a_ra2), .rd1(a_rd1), .rd2(a_rd2),
    .busy1(a_b1), .busy2(a_b2), .sb_set(a_ss), .sb_sa(a_sa),
    .busy_cnt(a_cnt), .dbg_sel(a_dsel), .dbg_data(a_dbg)
  );

  // Instance B: DW=64, AW=4, no bypass, no hardwired zero
  localparam int MB = 0;
  localparam int MZ = 0;
  logic        b_we, b_ss;
  logic [3:0]  b_wa, b_ra1, b_ra2, b_sa, b_dsel;
  logic [63:0] b_wd, b_rd1, b_rd2, b_dbg;
  logic        b_b1, b_b2;
  logic [4:0]  b_cnt;

  rf_bypass_sb #(.DW(64), .AW(4), .BYPASS(MB), .ZERO_REG(MZ)) u_dut_b (
    .clk(clk), .rst(rst), .we(b_we), .wa(b_wa), .wd(b_wd),
    .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
    .busy1(b_b1), .busy2(b_b2), .sb_set(b_ss), .sb_sa(b_sa),
    .busy_cnt(b_cnt), .dbg_sel(b_dsel), .dbg_data(b_dbg)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1, ra2;
    logic        ss;
    logic [4:0]  sa, dsel;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2;
    logic [5:0]  e_cnt;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra1, input logic [4:0] ra2,
                     input logic ss, input logic [4:0] sa, input logic [4:0] dsel,
                     input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                     input logic e_b1, input logic e_b2, input logic [5:0] e_cnt,
                     input logic [31:0] e_dbg);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2;
    v.ss = ss; v.sa = sa; v.dsel = dsel;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_cnt = e_cnt; v.e_dbg = e_dbg;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_wa = '0; a_wd = '0; a_ra1 = '0; a_ra2 = '0;
    a_ss = 1'b0; a_sa = '0; a_dsel = '0;
  endtask

  task automatic b_idle();
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra1 = '0; b_ra2 = '0;
    b_ss = 1'b0; b_sa = '0; b_dsel = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model for instance B
  logic [63:0] m_rf [16];
  logic [15:0] m_busy;

  function automatic logic [63:0] m_rd(input logic [3:0] ra);
    if (MZ != 0 && ra == 4'd0) return 64'd0;
    if (MB != 0 && b_we && b_wa == ra) return b_wd;
    return m_rf[ra];
  endfunction

  function automatic logic m_bz(input logic [3:0] ra);
    if (MZ != 0 && ra == 4'd0) return 1'b0;
    if (MB != 0 && b_we && b_wa == ra && !(b_ss && b_sa == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  initial begin
    a_idle();
    b_idle();

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd1", 64'(a_rd1), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- table-driven directed vectors ----------------
    //   we wa  wd             ra1 ra2 ss sa dsel  rd1            rd2            b1 b2 cnt dbg
    add(0, 0,  32'h0,          5,  7,  0, 0, 0,    32'h0,         32'h0,         0, 0, 0, 32'h0);
    add(1, 5,  32'hDEADBEEF,   5,  0,  0, 0, 5,    32'hDEADBEEF,  32'h0,         0, 0, 0, 32'h0);
    add(1, 7,  32'h11111111,   5,  7,  0, 0, 5,    32'hDEADBEEF,  32'h11111111,  0, 0, 0, 32'hDEADBEEF);
    add(1, 7,  32'hA5A5A5A5,   7,  7,  0, 0, 7,    32'hA5A5A5A5,  32'hA5A5A5A5,  0, 0, 0, 32'h11111111);
    add(0, 0,  32'h0,          7,  5,  0, 0, 7,    32'hA5A5A5A5,  32'hDEADBEEF,  0, 0, 0, 32'hA5A5A5A5);
    add(1, 0,  32'h1234,       0,  0,  0, 0, 0,    32'h0,         32'h0,         0, 0, 0, 32'h0);
    add(0, 0,  32'h0,          0,  0,  1, 0, 0,    32'h0,         32'h0,         0, 0, 0, 32'h0);
    add(0, 0,  32'h0,          0,  0,  0, 0, 0,    32'h0,         32'h0,         0, 0, 0, 32'h0);
    add(0, 0,  32'h0,          3,  3,  1, 3, 0,    32'h0,         32'h0,         0, 0, 0, 32'h0);
    add(0, 0,  32'h0,          3,  0,  0, 0, 0,    32'h0,         32'h0,         1, 0, 1, 32'h0);
    add(1, 3,  32'h33,         3,  3,  0, 0, 3,    32'h33,        32'h33,        0, 0, 1, 32'h0);
    add(0, 0,  32'h0,          3,  0,  0, 0, 3,    32'h33,        32'h0,         0, 0, 0, 32'h33);
    add(0, 0,  32'h0,          9,  0,  1, 9, 0,    32'h0,         32'h0,         0, 0, 0, 32'h0);
    add(1, 9,  32'h55,         9,  9,  1, 9, 9,    32'h55,        32'h55,        1, 1, 1, 32'h0);
    add(0, 0,  32'h0,          9,  0,  0, 0, 9,    32'h55,        32'h0,         1, 0, 1, 32'h55);
    add(1, 9,  32'h66,         9,  10, 1, 10, 0,   32'h66,        32'h0,         0, 0, 1, 32'h0);
    add(0, 0,  32'h0,          9,  10, 0, 0, 0,    32'h66,        32'h0,         0, 1, 1, 32'h0);
    add(1, 12, 32'h77,         10, 12, 0, 0, 0,    32'h0,         32'h77,        1, 0, 1, 32'h0);
    add(0, 0,  32'h0,          12, 10, 0, 0, 12,   32'h77,        32'h0,         0, 1, 1, 32'h77);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      a_we = tv[i].we; a_wa = tv[i].wa; a_wd = tv[i].wd;
      a_ra1 = tv[i].ra1; a_ra2 = tv[i].ra2;
      a_ss = tv[i].ss; a_sa = tv[i].sa; a_dsel = tv[i].dsel;
      #1;
      chk($sformatf("v%0d_rd1", i), 64'(a_rd1), 64'(tv[i].e_rd1));
      chk($sformatf("v%0d_rd2", i), 64'(a_rd2), 64'(tv[i].e_rd2));
      chk($sformatf("v%0d_busy1", i), 64'(a_b1), 64'(tv[i].e_b1));
      chk($sformatf("v%0d_busy2", i), 64'(a_b2), 64'(tv[i].e_b2));
      chk($sformatf("v%0d_cnt", i), 64'(a_cnt), 64'(tv[i].e_cnt));
      chk($sformatf("v%0d_dbg", i), 64'(a_dbg), 64'(tv[i].e_dbg));
    end

    // ---------------- asynchronous reset mid-run ----------------
    @(negedge clk);
    a_idle();
    a_ra1 = 5'd5; a_ra2 = 5'd10; a_dsel = 5'd5;
    rst = 1'b0;
    #1;
    chk("amid_rd1", 64'(a_rd1), 64'd0);
    chk("amid_busy2", 64'(a_b2), 64'd0);
    chk("amid_cnt", 64'(a_cnt), 64'd0);
    chk("amid_dbg", 64'(a_dbg), 64'd0);
    a_we = 1'b1; a_wa = 5'd6; a_wd = 32'hCAFE0001; a_ra2 = 5'd6;
    #1;
    chk("amid_bypass_live", 64'(a_rd2), 64'h0000_0000_CAFE_0001);
    @(negedge clk);
    rst = 1'b1;
    a_we = 1'b0;
    #1;
    chk("amid_no_write", 64'(a_rd2), 64'd0);

    // ---------------- counter fill and saturation ----------------
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      a_ss = 1'b1; a_sa = 5'(i);
      step();
      chk($sformatf("fill_cnt%0d", i), 64'(a_cnt), 64'(i));
    end
    @(negedge clk);
    a_sa = 5'd4;
    step();
    chk("reset4_cnt", 64'(a_cnt), 64'd31);
    @(negedge clk);
    a_sa = 5'd0;
    step();
    chk("set0_cnt", 64'(a_cnt), 64'd31);
    @(negedge clk);
    a_sa = 5'd6; a_we = 1'b1; a_wa = 5'd4; a_wd = 32'h44;
    a_ra1 = 5'd4; a_ra2 = 5'd6;
    step();
    a_ss = 1'b0; a_we = 1'b0;
    #1;
    chk("w4s6_cnt", 64'(a_cnt), 64'd30);
    chk("w4s6_busy1", 64'(a_b1), 64'd0);
    chk("w4s6_busy2", 64'(a_b2), 64'd1);
    chk("w4s6_rd1", 64'(a_rd1), 64'h44);

    // ---------------- instance B: no bypass ----------------
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    b_we = 1'b1; b_wa = 4'd7; b_wd = 64'h0123456789ABCDEF; b_ra2 = 4'd7; b_dsel = 4'd7;
    #1;
    chk("nob_rd2_old", b_rd2, 64'd0);
    step();
    b_we = 1'b0;
    #1;
    chk("nob_rd2_new", b_rd2, 64'h0123456789ABCDEF);
    chk("nob_dbg", b_dbg, 64'h0123456789ABCDEF);
    @(negedge clk);
    b_ss = 1'b1; b_sa = 4'd7;
    step();
    b_ss = 1'b0;
    #1;
    chk("nob_cnt1", 64'(b_cnt), 64'd1);
    @(negedge clk);
    b_we = 1'b1; b_wa = 4'd7; b_wd = 64'hFEDCBA9876543210; b_ra1 = 4'd7;
    #1;
    chk("nob_busy_held", 64'(b_b1), 64'd1);
    chk("nob_rd1_old", b_rd1, 64'h0123456789ABCDEF);
    step();
    b_we = 1'b0;
    #1;
    chk("nob_busy_clr", 64'(b_b1), 64'd0);
    chk("nob_cnt0", 64'(b_cnt), 64'd0);

    // ---------------- instance B: random against model ----------------
    @(negedge clk); rst = 1'b0;
    b_idle();
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_busy = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      b_we   = ($urandom_range(0, 1) == 1);
      b_wa   = 4'($urandom_range(0, 15));
      b_wd   = {$urandom, $urandom};
      b_ra1  = 4'($urandom_range(0, 15));
      b_ra2  = ($urandom_range(0, 3) == 0) ? b_wa : 4'($urandom_range(0, 15));
      b_ss   = ($urandom_range(0, 4) < 2);
      b_sa   = ($urandom_range(0, 3) == 0) ? b_wa : 4'($urandom_range(0, 15));
      b_dsel = 4'($urandom_range(0, 15));
      #1;
      chk($sformatf("rnd%0d_rd1", n), b_rd1, m_rd(b_ra1));
      chk($sformatf("rnd%0d_rd2", n), b_rd2, m_rd(b_ra2));
      chk($sformatf("rnd%0d_busy1", n), 64'(b_b1), 64'(m_bz(b_ra1)));
      chk($sformatf("rnd%0d_busy2", n), 64'(b_b2), 64'(m_bz(b_ra2)));
      chk($sformatf("rnd%0d_cnt", n), 64'(b_cnt), 64'($countones(m_busy)));
      if (b_we && !(MZ != 0 && b_wa == 4'd0)) m_rf[b_wa] = b_wd;
      if (b_we) m_busy[b_wa] = 1'b0;
      if (b_ss && !(MZ != 0 && b_sa == 4'd0)) m_busy[b_sa] = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
